// File: rtl/riscv_mc_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface riscv_mc_controller_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       OpCode;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic             ZERO;
    logic             PCWrite;
    logic             AdrSrc;
    logic             MemWrite;
    logic             IRWrite;
    logic [1:0]       ResultSrc;
    logic [2:0]       ALUControl;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [2:0]       ImmSrc;
    logic             RegWrite;
    logic             illegal;
    logic [3:0]       state_dbg;
    logic [CNT_W-1:0] instret;

    modport master (
        input  OpCode, f3, f7, ZERO,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
        output ALUControl, ALUSrcA, ALUSrcB, ImmSrc, RegWrite,
        output illegal, state_dbg, instret
    );

    modport slave (
        output OpCode, f3, f7, ZERO,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
        input  ALUControl, ALUSrcA, ALUSrcB, ImmSrc, RegWrite,
        input  illegal, state_dbg, instret
    );
endinterface

// File: rtl/riscv_mc_controller.sv
// Multicycle RV32I-subset control FSM with sticky illegal-instruction
// trap and retired-instruction counter.
module riscv_mc_controller #(
    parameter int CNT_W = 32
) (
    input logic                   clk,
    input logic                   rst,
    riscv_mc_controller_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LINK     = 4'd12,
        S_LUI      = 4'd13,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_PASS = 3'b110;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    state_t     dec_nxt;
    logic       r_ok, i_ok, b_ok;
    logic [2:0] alu_f3;

    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, src_a, src_b;
    logic [2:0] alu_ctl, imm_src;

    // Legality of the field combinations this datapath implements
    always_comb begin
        r_ok = ((bus.f3 == 3'b000) &&
                ((bus.f7 == 7'b0000000) || (bus.f7 == 7'b0100000))) ||
               (((bus.f3 == 3'b111) || (bus.f3 == 3'b110) ||
                 (bus.f3 == 3'b010) || (bus.f3 == 3'b100)) &&
                (bus.f7 == 7'b0000000));
        i_ok = (bus.f3 == 3'b000) || (bus.f3 == 3'b111) ||
               (bus.f3 == 3'b110) || (bus.f3 == 3'b010) ||
               (bus.f3 == 3'b100);
        b_ok = (bus.f3 == 3'b000) || (bus.f3 == 3'b001) ||
               (bus.f3 == 3'b100) || (bus.f3 == 3'b101);
        unique case (bus.f3)
            3'b111:  alu_f3 = ALU_AND;
            3'b110:  alu_f3 = ALU_OR;
            3'b010:  alu_f3 = ALU_SLT;
            3'b100:  alu_f3 = ALU_XOR;
            default: alu_f3 = ALU_ADD;
        endcase
    end

    // Opcode dispatch out of DECODE; anything unrecognised traps
    always_comb begin
        dec_nxt = S_TRAP;
        case (bus.OpCode)
            OP_LOAD:  if (bus.f3 == 3'b010) dec_nxt = S_MEMADR;
            OP_STORE: if (bus.f3 == 3'b010) dec_nxt = S_MEMADR;
            OP_R:     if (r_ok) dec_nxt = S_EXECR;
            OP_I:     if (i_ok) dec_nxt = S_EXECI;
            OP_BR:    if (b_ok) dec_nxt = S_BRANCH;
            OP_JAL:   dec_nxt = S_JAL;
            OP_JALR:  if (bus.f3 == 3'b000) dec_nxt = S_JALR;
            OP_LUI:   dec_nxt = S_LUI;
            default:  dec_nxt = S_TRAP;
        endcase
    end

    // Next state and Moore-style control outputs
    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'd0;
        src_a      = 2'd0;
        src_b      = 2'd0;
        alu_ctl    = ALU_ADD;
        imm_src    = IMM_I;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                src_b      = 2'd2;
                result_src = 2'd2;
                pc_write   = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                src_a   = 2'd1;
                src_b   = 2'd1;
                imm_src = (bus.OpCode == OP_JAL) ? IMM_J : IMM_B;
                state_d = dec_nxt;
            end
            S_MEMADR: begin
                src_a   = 2'd2;
                src_b   = 2'd1;
                imm_src = (bus.OpCode == OP_STORE) ? IMM_S : IMM_I;
                state_d = (bus.OpCode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'd1;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXECR: begin
                src_a   = 2'd2;
                alu_ctl = alu_f3;
                if (bus.f3 == 3'b000 && bus.f7 == 7'b0100000)
                    alu_ctl = ALU_SUB;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                src_a   = 2'd2;
                src_b   = 2'd1;
                alu_ctl = alu_f3;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                src_a = 2'd2;
                case (bus.f3)
                    3'b000: begin alu_ctl = ALU_SUB; pc_write = bus.ZERO;  end
                    3'b001: begin alu_ctl = ALU_SUB; pc_write = ~bus.ZERO; end
                    3'b100: begin alu_ctl = ALU_SLT; pc_write = ~bus.ZERO; end
                    3'b101: begin alu_ctl = ALU_SLT; pc_write = bus.ZERO;  end
                    default: ;
                endcase
                state_d = S_FETCH;
            end
            S_JAL: begin
                pc_write = 1'b1;
                src_a    = 2'd1;
                src_b    = 2'd2;
                state_d  = S_ALUWB;
            end
            S_JALR: begin
                src_a      = 2'd2;
                src_b      = 2'd1;
                result_src = 2'd2;
                pc_write   = 1'b1;
                state_d    = S_LINK;
            end
            S_LINK: begin
                src_a   = 2'd1;
                src_b   = 2'd2;
                state_d = S_ALUWB;
            end
            S_LUI: begin
                src_b   = 2'd1;
                imm_src = IMM_U;
                alu_ctl = ALU_PASS;
                state_d = S_ALUWB;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    // Trap flag is sticky; instret counts the final cycle of each instruction
    always_comb begin
        illegal_d = illegal_q | (state_d == S_TRAP);
        instret_d = instret_q;
        if (state_q == S_MEMWB || state_q == S_MEMWRITE ||
            state_q == S_ALUWB || state_q == S_BRANCH)
            instret_d = instret_q + 1'b1;
    end

    // State, trap flag and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    assign bus.PCWrite    = pc_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.MemWrite   = mem_write;
    assign bus.IRWrite    = ir_write;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUControl = alu_ctl;
    assign bus.ALUSrcA    = src_a;
    assign bus.ALUSrcB    = src_b;
    assign bus.ImmSrc     = imm_src;
    assign bus.RegWrite   = reg_write;
    assign bus.illegal    = illegal_q;
    assign bus.state_dbg  = state_q;
    assign bus.instret    = instret_q;
endmodule

// File: doc/riscv_mc_controller.md
Name: riscv_mc_controller

Overview:
- Multicycle control unit for the RV32I-subset datapath; consumes OpCode/f3/f7/ZERO from the datapath, drives all of its select and enable inputs.
- Moore-style FSM; outputs are combinational from state plus the instruction fields, which are held stable in the instruction register after FETCH.
- Adds a sticky illegal-instruction trap and a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  clock
rst  input  1  reset
OpCode  input  7  Instr[6:0]
f3  input  3  Instr[14:12]
f7  input  7  Instr[31:25]
ZERO  input  1  ALU zero flag
PCWrite  output  1  PC load enable
AdrSrc  output  1  memory address select: 0=PC, 1=Result
MemWrite  output  1  memory write enable
IRWrite  output  1  IR/OldPC load enable
ResultSrc  output  2  0=ALUOut, 1=MemData, 2=ALUResult
ALUControl  output  3  ADD 000, SUB 001, AND 010, OR 011, SLT 100, XOR 101, PASS 110
ALUSrcA  output  2  0=PC, 1=OldPC, 2=A
ALUSrcB  output  2  0=rs2 (WriteData), 1=ImmExt, 2=constant 4
ImmSrc  output  3  I 000, S 001, B 010, J 011, U 100
RegWrite  output  1  register file write enable
illegal  output  1  sticky trap flag
state_dbg  output  4  current state encoding
instret  output  CNT_W  retired-instruction count

Behaviour:
- Reset: rst is asynchronous, active-high; clk is the clock.
- Reset effects: state=FETCH, illegal=0, instret=0. While in reset, outputs show the FETCH decode. The datapath is also held in reset, so this is harmless.
- Default for every output not listed in a state: 0. Default ALUControl: ADD. Default ImmSrc: I.
- State encoding:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7
  - ALUWB 8, BRANCH 9, JAL 10, JALR 11, LINK 12, LUI 13, TRAP 15
- FETCH: AdrSrc=0, IRWrite=1, SrcA=0, SrcB=2, ADD, ResultSrc=2, PCWrite=1. Next: DECODE.
- DECODE: SrcA=1, SrcB=1, ADD; ImmSrc=J if OpCode=1101111, else B. Next by opcode:
  - 0000011 (lw, f3=010) or 0100011 (sw, f3=010) -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 (f3=000) -> JALR
  - 0110111 -> LUI
  - anything else, or a listed opcode with an unlisted f3/f7 -> TRAP
- MEMADR: SrcA=2, SrcB=1, ADD; ImmSrc=S for sw, I for lw. Next: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=0. Next: MEMWB.
- MEMWB: ResultSrc=1, RegWrite=1. Next: FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=0, MemWrite=1. Next: FETCH.
- EXECR: SrcA=2, SrcB=0. Op decode:
  - f3=000: f7=0000000 ADD, f7=0100000 SUB
  - f3=111 AND, 110 OR, 010 SLT, 100 XOR; each requires f7=0
  - Next: ALUWB.
- EXECI: SrcA=2, SrcB=1, ImmSrc=I. f3 000/111/110/010/100 -> ADD/AND/OR/SLT/XOR. Next: ALUWB.
- ALUWB: ResultSrc=0, RegWrite=1. Next: FETCH.
- BRANCH: SrcA=2, SrcB=0, ResultSrc=0 (target computed in DECODE).
  - beq(000): SUB, PCWrite=ZERO
  - bne(001): SUB, PCWrite=~ZERO
  - blt(100): SLT, PCWrite=~ZERO
  - bge(101): SLT, PCWrite=ZERO
  - Next: FETCH.
- JAL: ResultSrc=0, PCWrite=1 (PC<=target); SrcA=1, SrcB=2, ADD (link = OldPC+4 into ALUOut). Next: ALUWB.
- JALR: SrcA=2, SrcB=1, ImmSrc=I, ADD, ResultSrc=2, PCWrite=1. Next: LINK.
- LINK: SrcA=1, SrcB=2, ADD. Next: ALUWB.
- LUI: SrcB=1, ImmSrc=U, PASS. Next: ALUWB.
- TRAP: all enables 0, illegal=1. Stays in TRAP until rst. Never asserts PCWrite, RegWrite or MemWrite.
- Instruction latency: R/I/lui = 4 cycles, lw = 5, sw = 4, branch = 3, jal = 4, jalr = 5.
- instret: increments by 1 on each clock edge that leaves MEMWB, MEMWRITE, ALUWB or BRANCH. Wraps modulo 2^CNT_W; no saturation. Does not increment on entering TRAP.
- Reset mid-instruction: returns to FETCH immediately. No partial write is issued after rst deasserts.
- Enable outputs PCWrite/MemWrite/RegWrite/IRWrite never assert in a state not listed for them.

Test Plan:
- add x3,x1,x2 (0x002081B3) after reset -> states 0,1,6,8,0; ALUControl=000 in EXECR; RegWrite=1 only in ALUWB; instret 0->1.
- sub (f7=0100000, f3=000) -> ALUControl=001 in EXECR. lw (0x0000A183) -> states 0,1,2,3,4; AdrSrc=1 in MEMREAD; ResultSrc=1 with RegWrite=1 in MEMWB.
- Branches, ZERO=1 in BRANCH:
  - beq -> PCWrite=1
  - bne -> PCWrite=0
  - blt -> ALUControl=100, PCWrite=0
  - bge -> PCWrite=1
- Branches repeated with ZERO=0 -> beq/bne/blt/bge give the inverted PCWrite; 3 cycles each.
- jal -> DECODE ImmSrc=011; JAL state PCWrite=1, ResultSrc=0. jalr -> states 0,1,11,12,8; PCWrite=1 only in FETCH and JALR.
- OpCode=0x7F or R-type f3=001 -> TRAP (15), illegal=1 held for 20 cycles, no enables asserted; rst pulse -> FETCH, illegal=0, instret=0. Counter preloaded near wrap (CNT_W=4, 16 retirements) -> instret wraps to 0.
